inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the R-type opcode decoder.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register (IR) and presents the decoded fields (OP, func, rs, rt, rd, shamt) to the decoder and register file with a valid/ready handshake.
- No branch handling: the PC advances sequentially.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; must be word aligned.
- TIMEOUT, 16, maximum number of cycles FETCH waits for imem_ack before error; range 2..65535.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; when low, no new fetch is started.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  read address; bits [1:0] are always 0.
- imem_rdata  in  32  read data; sampled only on the imem_ack cycle.
- imem_ack  in  1  one-cycle data-valid strobe from memory.
- ir_valid  out  1  IR holds an instruction not yet consumed.
- ir_ready  in  1  downstream can accept the instruction.
- OP  out  6  IR[31:26].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- shamt  out  5  IR[10:6].
- func  out  6  IR[5:0].
- ir_pc  out  32  address the current IR was fetched from.
- pc  out  32  address of the next fetch.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_PC, ir_pc=RESET_PC, IR=0 (all field outputs 0).
  - imem_req=0, imem_addr=RESET_PC, ir_valid=0, fetch_err=0, timeout counter=0.
  - State=IDLE.
- All outputs are registered; field outputs are pure slices of IR.
- FSM states: IDLE, FETCH, VALID, ERR.
- IDLE:
  - With en=1, go to FETCH on the next edge; imem_req=1 and imem_addr=pc take effect on that same edge.
  - With en=0, stay in IDLE.
- FETCH:
  - imem_req and imem_addr are held stable until ack.
  - On imem_ack=1: IR<=imem_rdata, ir_pc<=pc, pc<=pc+4, ir_valid<=1, imem_req<=0, counter<=0, go to VALID.
  - PC wraps: 32'hFFFFFFFC+4 = 32'h00000000; no flag is raised.
  - Each cycle without ack, counter increments.
  - If counter==TIMEOUT-1 and no ack: imem_req<=0, fetch_err<=1, go to ERR.
  - Ack on the limit cycle wins: normal capture, no error.
  - en deasserted in FETCH does not abort; the outstanding fetch completes.
- VALID:
  - ir_valid=1; IR and fields are stable while ir_ready=0 (no limit on stall length).
  - Transfer occurs on a cycle with ir_valid=1 and ir_ready=1.
  - At transfer: ir_valid<=0; with en=1, go to FETCH (imem_req=1, imem_addr=pc on the same edge); with en=0, go to IDLE.
  - IR keeps its last value after transfer; fields are don't-care for the consumer while ir_valid=0.
- ERR:
  - imem_req=0, ir_valid=0, fetch_err=1.
  - Leaves ERR only on rst.
- imem_ack outside FETCH is ignored: no state, PC or IR change.
- Reset during FETCH or VALID drops the request and valid immediately; a late ack after reset release is ignored because the FSM is in IDLE.
- Throughput with ready always high and ack latency L (cycles from req asserted to ack): one instruction every L+2 cycles.

Test Plan:
- Reset check: assert rst mid-cycle with clk held → pc=0, imem_req=0, ir_valid=0, fetch_err=0, OP=func=0 with no clock edge.
- Basic fetch: en=1, memory acks 2 cycles after req with 32'h012A4020 → OP=0, rs=9, rt=10, rd=8, shamt=0, func=6'h20; ir_pc=0, pc=4, ir_valid=1.
- Backpressure: hold ir_ready=0 for 5 cycles after valid → fields, ir_pc and ir_valid unchanged, imem_req=0; ready=1 → next request to addr 4 on the following edge.
- Timeout: TIMEOUT=16, never ack → fetch_err=1 and imem_req=0 after the 16th FETCH cycle; a later ack and en toggling cause no change until rst. Separate run with ack on exactly the 16th cycle → normal capture, fetch_err=0.
- Wrap: RESET_PC=32'hFFFFFFFC, one fetch → ir_pc=32'hFFFFFFFC, pc=0, next imem_addr=0.
- en low / stray ack: drop en during FETCH → fetch completes and the FSM returns to IDLE after transfer. Pulse imem_ack in IDLE with rdata=32'hFFFFFFFF → IR and pc unchanged.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: sequential instruction fetch stage feeding the R-type decoder.
//   Holds the PC, issues word reads over an imem req/ack handshake, latches the
//   returned word into the IR and offers its fields downstream with valid/ready.
//   No branch handling; the PC only advances by 4 and wraps silently.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              run enable; gates the start of a new fetch only
//   imem_req/addr   read request and word-aligned address (held until ack)
//   imem_rdata/ack  read data, valid on the single-cycle ack strobe
//   ir_valid/ready  downstream handshake for the IR contents
//   OP rs rt rd shamt func   slices of the IR
//   ir_pc           address the current IR was fetched from
//   pc              address of the next fetch
//   fetch_err       sticky flag: memory failed to ack within TIMEOUT cycles
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [5:0]  OP,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func,
    output logic [31:0] ir_pc,
    output logic [31:0] pc,
    output logic        fetch_err
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    // Low bits forced to zero so a misaligned parameter cannot leak onto the bus.
    localparam logic [31:0] PC_INIT  = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   ir;
    logic [CW-1:0] cnt;

    // Fetch FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= PC_INIT;
            ir_pc     <= PC_INIT;
            ir        <= 32'h0;
            imem_req  <= 1'b0;
            imem_addr <= PC_INIT;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        cnt       <= '0;
                    end
                end

                FETCH: begin
                    // Ack on the limit cycle still captures normally.
                    if (imem_ack) begin
                        ir        <= imem_rdata;
                        ir_pc     <= pc;
                        pc        <= pc + PC_STEP;
                        ir_valid  <= 1'b1;
                        imem_req  <= 1'b0;
                        cnt       <= '0;
                        state     <= VALID;
                    end else if (cnt == CNT_LAST) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                VALID: begin
                    // Back-to-back request on the transfer edge when still enabled.
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        if (en) begin
                            state     <= FETCH;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            cnt       <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                ERR: begin
                    // Terminal until reset.
                    imem_req  <= 1'b0;
                    ir_valid  <= 1'b0;
                    fetch_err <= 1'b1;
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

    // Decoded fields are plain slices of the IR register.
    assign OP    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign func  = ir[5:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory responses push expected {word, addr}
// entries into a scoreboard that is popped when the IR is observed valid.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, ir_ready, imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req, ir_valid, fetch_err;
    logic [31:0] imem_addr, ir_pc, pc;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;

    // Second instance exercising PC wrap-around.
    logic        w_en, w_ir_ready, w_imem_ack;
    logic [31:0] w_imem_rdata;
    logic        w_imem_req, w_ir_valid, w_fetch_err;
    logic [31:0] w_imem_addr, w_ir_pc, w_pc;
    logic [5:0]  w_op, w_func;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;
    exp_t sb[$];

    wire [31:0] ir_obs   = {op, rs, rt, rd, shamt, func};
    wire [31:0] w_ir_obs = {w_op, w_rs, w_rt, w_rd, w_shamt, w_func};

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .ir_valid(ir_valid), .ir_ready(ir_ready),
        .OP(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
        .ir_pc(ir_pc), .pc(pc), .fetch_err(fetch_err)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) dut_w (
        .clk(clk), .rst(rst), .en(w_en),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .imem_ack(w_imem_ack),
        .ir_valid(w_ir_valid), .ir_ready(w_ir_ready),
        .OP(w_op), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt), .func(w_func),
        .ir_pc(w_ir_pc), .pc(w_pc), .fetch_err(w_fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait (at negedges) for the main DUT to raise imem_req.
    task automatic wait_req(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (imem_req === 1'b1) break;
            @(negedge clk);
        end
        check({tag, "_req_seen"}, imem_req, 1);
    endtask

    // Called in the first FETCH cycle: lat cycles without ack, then one ack cycle.
    task automatic respond(input string tag, input int lat, input logic [31:0] word);
        logic [31:0] a;
        a = imem_addr;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
        end
        check({tag, "_req_held"}, imem_req, 1);
        check({tag, "_addr_held"}, imem_addr, a);
        sb.push_back('{word: word, addr: a});
        imem_rdata = word;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic check_capture(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, observed ir %h", tag, ir_obs);
            return;
        end
        e = sb.pop_front();
        check({tag, "_valid"}, ir_valid, 1);
        check({tag, "_ir"}, ir_obs, e.word);
        check({tag, "_ir_pc"}, ir_pc, e.addr);
        check({tag, "_pc"}, pc, 32'(e.addr + 32'd4));
        check({tag, "_req_low"}, imem_req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; ir_ready = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        w_en = 1'b0; w_ir_ready = 1'b0; w_imem_ack = 1'b0; w_imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Post-reset state.
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_req", imem_req, 0);
        check("rst_valid", ir_valid, 0);
        check("rst_err", fetch_err, 0);
        check("rst_ir", ir_obs, 32'h0);
        check("rst_w_pc", w_pc, 32'hFFFF_FFFC);

        // PC wrap on the second instance.
        w_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (w_imem_req === 1'b1) break;
            @(negedge clk);
        end
        check("wrap_req_seen", w_imem_req, 1);
        check("wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        sb.push_back('{word: 32'h1234_5678, addr: w_imem_addr});
        w_imem_rdata = 32'h1234_5678;
        w_imem_ack   = 1'b1;
        @(negedge clk);
        w_imem_ack   = 1'b0;
        begin
            exp_t e;
            e = sb.pop_front();
            check("wrap_valid", w_ir_valid, 1);
            check("wrap_ir", w_ir_obs, e.word);
            check("wrap_ir_pc", w_ir_pc, e.addr);
            check("wrap_pc", w_pc, 32'h0);
        end
        w_ir_ready = 1'b1;
        @(negedge clk);
        check("wrap_next_addr", w_imem_addr, 32'h0);
        check("wrap_next_req", w_imem_req, 1);
        w_ir_ready = 1'b0;
        w_en = 1'b0;

        // Basic fetch with two idle FETCH cycles before ack.
        en = 1'b1;
        wait_req("basic");
        check("basic_addr", imem_addr, 32'h0);
        respond("basic", 2, 32'h012A_4020);
        check("basic_op", op, 0);
        check("basic_rs", rs, 9);
        check("basic_rt", rt, 10);
        check("basic_rd", rd, 8);
        check("basic_shamt", shamt, 0);
        check("basic_func", func, 32'h20);
        check_capture("basic");

        // Backpressure: IR held while ready is low.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", ir_valid, 1);
            check("bp_ir", ir_obs, 32'h012A_4020);
            check("bp_ir_pc", ir_pc, 32'h0);
            check("bp_req", imem_req, 0);
        end
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        check("bp_xfer_valid", ir_valid, 0);
        check("bp_next_req", imem_req, 1);
        check("bp_next_addr", imem_addr, 32'h4);

        // en dropped mid-fetch: fetch completes, then IDLE after transfer.
        en = 1'b0;
        respond("enlow", 1, 32'h0085_3022);
        check_capture("enlow");
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        check("enlow_xfer_valid", ir_valid, 0);
        check("enlow_idle_req", imem_req, 0);
        @(negedge clk);
        check("enlow_idle_req2", imem_req, 0);

        // Stray ack in IDLE is ignored.
        imem_rdata = 32'hFFFF_FFFF;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);
        check("stray_pc", pc, 32'h8);
        check("stray_ir", ir_obs, 32'h0085_3022);
        check("stray_ir_pc", ir_pc, 32'h4);
        check("stray_valid", ir_valid, 0);

        // Asynchronous reset asserted mid-cycle during FETCH.
        en = 1'b1;
        wait_req("arst");
        #2 rst = 1'b1;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_req", imem_req, 0);
        check("arst_valid", ir_valid, 0);
        check("arst_err", fetch_err, 0);
        check("arst_op", op, 0);
        check("arst_func", func, 0);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);
        check("late_ack_pc", pc, 32'h0);
        check("late_ack_valid", ir_valid, 0);
        check("late_ack_ir", ir_obs, 32'h0);

        // Ack on the 16th FETCH cycle captures normally.
        en = 1'b1;
        wait_req("limit");
        respond("limit", 15, 32'h0109_5020);
        check_capture("limit");
        check("limit_err", fetch_err, 0);
        en = 1'b0;
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        check("limit_idle_req", imem_req, 0);

        // Timeout: no ack for 16 FETCH cycles.
        en = 1'b1;
        wait_req("tmo");
        for (int i = 0; i < 15; i++) @(negedge clk);
        check("tmo_16th_err", fetch_err, 0);
        check("tmo_16th_req", imem_req, 1);
        @(negedge clk);
        check("tmo_err", fetch_err, 1);
        check("tmo_req", imem_req, 0);
        imem_rdata = 32'hFFFF_FFFF;
        imem_ack   = 1'b1;
        en         = 1'b0;
        @(negedge clk);
        imem_ack   = 1'b0;
        en         = 1'b1;
        ir_ready   = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("err_sticky", fetch_err, 1);
        check("err_req", imem_req, 0);
        check("err_valid", ir_valid, 0);
        check("err_pc", pc, 32'h4);
        check("err_ir", ir_obs, 32'h0109_5020);
        ir_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared", fetch_err, 0);
        check("err_cleared_pc", pc, 32'h0);

        check("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
